// File: rtl/rr_mem_arbiter.sv
// Round-robin arbiter between NUM_CH cache channels and a single shared memory port.
// Registers the winning channel's command and holds it until mem_resp, which is then routed back to that channel.
module rr_mem_arbiter #(
  parameter  int NUM_CH = 2,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 256,
  localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_resp,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_resp,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic                     proto_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                proto_err_q, proto_err_d;

  logic [NUM_CH-1:0]   req;
  logic [ID_W-1:0]     win_lo, win_hi, win;
  logic                hi_found;
  logic                sel_rd, sel_wr;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Winner: lowest requester at or above rr_ptr, otherwise wrap to the lowest requester overall.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req      = ch_read | ch_write;
    win_lo   = '0;
    win_hi   = '0;
    hi_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) win_lo = ID_W'(i);
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i] && (ID_W'(i) >= rr_ptr_q)) begin
        win_hi   = ID_W'(i);
        hi_found = 1'b1;
      end
    end
    win = hi_found ? win_hi : win_lo;

    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ID_W'(i) == win) begin
        sel_rd    = ch_read[i];
        sel_wr    = ch_write[i];
        sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = ch_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    proto_err_d = proto_err_q;
    ch_resp     = '0;

    case (state_q)
      IDLE: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (|req) begin
          state_d     = BUSY;
          grant_id_d  = win;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          // A simultaneous read+write is served as a read and flagged.
          mem_read_d  = sel_rd;
          mem_write_d = sel_wr & ~sel_rd;
          if (sel_rd && sel_wr) proto_err_d = 1'b1;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          for (int i = 0; i < NUM_CH; i++) begin
            ch_resp[i] = (ID_W'(i) == grant_id_q);
          end
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          rr_ptr_d    = (grant_id_q == ID_W'(NUM_CH - 1)) ? '0 : grant_id_q + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the address/data registers are reset too, so mem_addr/mem_wdata read as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign ch_rdata  = mem_rdata;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q == BUSY);
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Self-checking bench for rr_mem_arbiter with four channels: a table of arbitration rounds plus
// hand-written sequences for latency, held commands, stray responses, protocol errors and reset.
module tb_rr_mem_arbiter;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 256;
  localparam int ID_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_read, ch_write, ch_resp;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [DATA_W-1:0]        ch_rdata, mem_wdata, mem_rdata;
  logic                     mem_read, mem_write, mem_resp;
  logic [ADDR_W-1:0]        mem_addr;
  logic [ID_W-1:0]          grant_id;
  logic                     busy, proto_err;

  rr_mem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ch_read(ch_read), .ch_write(ch_write), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_resp(ch_resp), .ch_rdata(ch_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ID_W-1:0]   grant;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct {
    logic [NUM_CH-1:0] rd;
    logic [NUM_CH-1:0] wr;
    int                grant;
    logic              exp_rd;
    logic              exp_wr;
  } vec_t;

  cmd_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [ADDR_W-1:0] addr_of(input int i);
    return 32'h0000_1000 + 32'(i) * 32'h20;
  endfunction

  function automatic logic [DATA_W-1:0] wdata_of(input int i);
    return {8{32'hD0D0_0000 | 32'(i)}};
  endfunction

  function automatic logic [DATA_W-1:0] rdata_of(input int i);
    return {8{32'h5A5A_0000 | 32'(i)}};
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_chan_data();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_addr[i*ADDR_W +: ADDR_W]  = addr_of(i);
      ch_wdata[i*DATA_W +: DATA_W] = wdata_of(i);
    end
  endtask

  task automatic push_exp(input int g, input logic rd, input logic wr);
    cmd_t c;
    c.grant = ID_W'(g);
    c.rd    = rd;
    c.wr    = wr;
    c.addr  = addr_of(g);
    c.wdata = wdata_of(g);
    exp_q.push_back(c);
  endtask

  // Bounded wait for a memory command; returns the number of clock edges it took.
  task automatic wait_cmd(input int budget, output int waited);
    waited = 0;
    while (!(mem_read || mem_write) && waited < budget) begin
      tick();
      waited++;
    end
  endtask

  task automatic expect_cmd(input string tag);
    cmd_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s_scoreboard: command seen with nothing expected", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_grant"}, DATA_W'(grant_id), DATA_W'(e.grant));
    check({tag, "_mem_read"}, DATA_W'(mem_read), DATA_W'(e.rd));
    check({tag, "_mem_write"}, DATA_W'(mem_write), DATA_W'(e.wr));
    check({tag, "_mem_addr"}, DATA_W'(mem_addr), DATA_W'(e.addr));
    check({tag, "_mem_wdata"}, mem_wdata, e.wdata);
  endtask

  // One full transaction from IDLE: drive requests, see the command, respond, release the winner.
  task automatic run_row(input vec_t v, input int idx);
    int                w;
    logic [NUM_CH-1:0] one;
    one      = 4'b0001 << v.grant;
    ch_read  = v.rd;
    ch_write = v.wr;
    push_exp(v.grant, v.exp_rd, v.exp_wr);
    wait_cmd(8, w);
    check("row_cmd_latency", DATA_W'(w), DATA_W'(1));
    expect_cmd("row");
    check("row_busy", DATA_W'(busy), DATA_W'(1));
    check("row_no_early_resp", DATA_W'(ch_resp), '0);
    tick();
    mem_resp  = 1'b1;
    mem_rdata = rdata_of(idx);
    #1;
    check("row_ch_resp", DATA_W'(ch_resp), DATA_W'(one));
    check("row_ch_rdata", ch_rdata, rdata_of(idx));
    tick();
    mem_resp          = 1'b0;
    ch_read[v.grant]  = 1'b0;
    ch_write[v.grant] = 1'b0;
    check("row_back_idle", DATA_W'({busy, mem_read, mem_write}), '0);
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int order[5];

    rst       = 1'b1;
    ch_read   = '0;
    ch_write  = '0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    load_chan_data();

    // Rows start with rr_ptr=3 (after the single ch2 read below).
    vecs[0] = '{rd: 4'b0001, wr: 4'b1000, grant: 3, exp_rd: 1'b0, exp_wr: 1'b1};
    vecs[1] = '{rd: 4'b0001, wr: 4'b0000, grant: 0, exp_rd: 1'b1, exp_wr: 1'b0};
    vecs[2] = '{rd: 4'b0110, wr: 4'b0000, grant: 1, exp_rd: 1'b1, exp_wr: 1'b0};
    vecs[3] = '{rd: 4'b0100, wr: 4'b0001, grant: 2, exp_rd: 1'b1, exp_wr: 1'b0};
    vecs[4] = '{rd: 4'b0000, wr: 4'b1001, grant: 3, exp_rd: 1'b0, exp_wr: 1'b1};
    vecs[5] = '{rd: 4'b0010, wr: 4'b0001, grant: 0, exp_rd: 1'b0, exp_wr: 1'b1};
    vecs[6] = '{rd: 4'b0010, wr: 4'b0000, grant: 1, exp_rd: 1'b1, exp_wr: 1'b0};

    // Reset and idle.
    tick();
    check("reset_outputs", DATA_W'({busy, mem_read, mem_write, proto_err, ch_resp, grant_id}), '0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_outputs", DATA_W'({busy, mem_read, mem_write, proto_err, ch_resp, grant_id}), '0);
    end
    check("idle_mem_addr", DATA_W'(mem_addr), '0);
    check("idle_mem_wdata", mem_wdata, '0);

    // Single ch2 read, response four cycles after the request.
    ch_read[2] = 1'b1;
    push_exp(2, 1'b1, 1'b0);
    tick();
    check("ch2_mem_addr_1040", DATA_W'(mem_addr), DATA_W'(32'h0000_1040));
    expect_cmd("ch2");
    for (int i = 0; i < 3; i++) begin
      check("ch2_mem_read_held", DATA_W'(mem_read), DATA_W'(1));
      check("ch2_no_resp_yet", DATA_W'(ch_resp), '0);
      tick();
    end
    mem_resp  = 1'b1;
    mem_rdata = {32{8'hA5}};
    #1;
    check("ch2_mem_read_last", DATA_W'(mem_read), DATA_W'(1));
    check("ch2_resp", DATA_W'(ch_resp), DATA_W'(4'b0100));
    check("ch2_rdata", ch_rdata, {32{8'hA5}});
    tick();
    mem_resp   = 1'b0;
    ch_read[2] = 1'b0;
    check("ch2_done", DATA_W'({busy, mem_read, ch_resp}), '0);

    for (int i = 0; i < 7; i++) run_row(vecs[i], i);

    // ch1 read; its address and request change mid-transaction, command must stay latched.
    ch_read = 4'b0010;
    push_exp(1, 1'b1, 1'b0);
    wait_cmd(8, w);
    check("hold_latency", DATA_W'(w), DATA_W'(1));
    expect_cmd("hold");
    ch_addr[1*ADDR_W +: ADDR_W] = 32'hDEAD_BEEF;
    ch_read = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold_mem_addr", DATA_W'(mem_addr), DATA_W'(addr_of(1)));
      check("hold_mem_read", DATA_W'({busy, mem_read}), DATA_W'(2'b11));
    end
    mem_resp = 1'b1;
    #1;
    check("hold_resp", DATA_W'(ch_resp), DATA_W'(4'b0010));
    tick();
    mem_resp = 1'b0;
    load_chan_data();
    tick();
    mem_resp = 1'b1;
    #1;
    check("stray_resp_ignored", DATA_W'(ch_resp), '0);
    tick();
    mem_resp = 1'b0;
    check("stray_stays_idle", DATA_W'({busy, mem_read, mem_write}), '0);

    // Read and write together on ch1: served as a read, proto_err sticks.
    ch_read  = 4'b0010;
    ch_write = 4'b0010;
    push_exp(1, 1'b1, 1'b0);
    wait_cmd(8, w);
    expect_cmd("rw");
    check("rw_proto_err", DATA_W'(proto_err), DATA_W'(1));
    tick();
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    ch_read  = '0;
    ch_write = '0;
    tick();
    tick();
    check("rw_proto_err_sticky", DATA_W'({busy, proto_err}), DATA_W'(2'b01));

    // Reset in the middle of a transaction.
    ch_read = 4'b0100;
    wait_cmd(8, w);
    check("rst_pre_busy", DATA_W'({busy, mem_read, grant_id}), DATA_W'({1'b1, 1'b1, 2'd2}));
    mem_resp = 1'b1;
    rst      = 1'b1;
    #1;
    check("rst_async_outputs", DATA_W'({busy, mem_read, mem_write, proto_err, grant_id}), '0);
    check("rst_no_resp", DATA_W'(ch_resp), '0);
    tick();
    mem_resp = 1'b0;
    ch_read  = '0;
    rst      = 1'b0;
    tick();

    // All channels requesting continuously, response two cycles after each command.
    order = '{0, 1, 2, 3, 0};
    for (int n = 0; n < 5; n++) push_exp(order[n], 1'b1, 1'b0);
    ch_read = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      logic [NUM_CH-1:0] one;
      one = 4'b0001 << order[n];
      wait_cmd(8, w);
      check("rr_dead_cycles", DATA_W'(w), DATA_W'(1));
      expect_cmd("rr");
      tick();
      tick();
      mem_resp  = 1'b1;
      mem_rdata = rdata_of(10 + n);
      #1;
      check("rr_ch_resp", DATA_W'(ch_resp), DATA_W'(one));
      tick();
      mem_resp = 1'b0;
    end
    ch_read = '0;
    check("scoreboard_drained", DATA_W'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
